// File: rtl/rec_a_unpacker.sv
// rec_a_unpacker: receive side of the record link. Rebuilds A records
// (a: 10 bit, aa: 10 bit, aaa: 32 bit) from little-endian byte frames
// of the form [header][payload]. Each record carries a B kind: X=1, Y=2, Z=3.
// Decoded records are offered one at a time through a one-entry holding register.
module rec_a_unpacker #(
  parameter bit STRICT_HDR = 1'b1,
  parameter bit STRICT_PAD = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [1:0]  o_kind,
  output logic [9:0]  o_a,
  output logic [9:0]  o_aa,
  output logic [31:0] o_aaa,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic {
    HDR = 1'b0,
    PAY = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [1:0]  kind, kind_next;
  logic [2:0]  count, count_next;
  logic        frame_err, frame_err_next;

  // Assembly registers; cleared on every good header so absent fields read 0.
  logic [9:0]  a_asm, a_next;
  logic [9:0]  aa_asm, aa_next;
  logic [31:0] aaa_asm, aaa_next;

  logic        accept;
  logic [2:0]  last_idx;
  logic        is_final;
  logic        is_high;
  logic        pad_bad;
  logic        hdr_bad;
  logic        drop;
  logic        load;
  logic        err_set;

  // Per-byte classification: frame position, pad and header checks.
  always_comb begin
    last_idx = 3'd1;
    case (kind)
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      2'd3:    last_idx = 3'd7;
      default: last_idx = 3'd1;
    endcase
    is_final = (state == PAY) && (count == last_idx);
    is_high  = (state == PAY) && ((count == 3'd1) || (count == 3'd3));
    pad_bad  = STRICT_PAD && is_high && (i_data[7:2] != 6'd0);
    hdr_bad  = (i_data[1:0] == 2'd0) || (STRICT_HDR && (i_data[7:2] != 6'd0));
    drop     = frame_err || pad_bad;
    // Only a good final byte has to wait for room in the output slot.
    o_ready  = !i_rst && (!is_final || drop || !o_valid || i_ready);
    accept   = i_valid && o_ready;
  end

  // State, kind, count, error flag and assembly registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= HDR;
      kind      <= 2'd0;
      count     <= 3'd0;
      frame_err <= 1'b0;
      a_asm     <= 10'd0;
      aa_asm    <= 10'd0;
      aaa_asm   <= 32'd0;
    end else begin
      state     <= state_next;
      kind      <= kind_next;
      count     <= count_next;
      frame_err <= frame_err_next;
      a_asm     <= a_next;
      aa_asm    <= aa_next;
      aaa_asm   <= aaa_next;
    end
  end

  // Next-state logic: header decode, lane writes and end-of-frame decision.
  always_comb begin
    state_next     = state;
    kind_next      = kind;
    count_next     = count;
    frame_err_next = frame_err;
    a_next         = a_asm;
    aa_next        = aa_asm;
    aaa_next       = aaa_asm;
    load           = 1'b0;
    err_set        = 1'b0;

    case (state)
      HDR: begin
        if (accept) begin
          if (hdr_bad) begin
            err_set = 1'b1;
          end else begin
            kind_next      = i_data[1:0];
            count_next     = 3'd0;
            frame_err_next = 1'b0;
            a_next         = 10'd0;
            aa_next        = 10'd0;
            aaa_next       = 32'd0;
            state_next     = PAY;
          end
        end
      end
      PAY: begin
        if (accept) begin
          case (count)
            3'd0: a_next[7:0]     = i_data;
            3'd1: a_next[9:8]     = i_data[1:0];
            3'd2: aa_next[7:0]    = i_data;
            3'd3: aa_next[9:8]    = i_data[1:0];
            3'd4: aaa_next[7:0]   = i_data;
            3'd5: aaa_next[15:8]  = i_data;
            3'd6: aaa_next[23:16] = i_data;
            3'd7: aaa_next[31:24] = i_data;
            default: ;
          endcase
          if (pad_bad) begin
            frame_err_next = 1'b1;
          end
          if (is_final) begin
            state_next = HDR;
            count_next = 3'd0;
            if (drop) begin
              err_set = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            count_next = count + 3'd1;
          end
        end
      end
      default: state_next = HDR;
    endcase
  end

  // One-entry output slot: loads a finished record, clears on consumption.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_kind  <= 2'd0;
      o_a     <= 10'd0;
      o_aa    <= 10'd0;
      o_aaa   <= 32'd0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_kind  <= kind;
      o_a     <= a_next;
      o_aa    <= aa_next;
      o_aaa   <= aaa_next;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Error pulse and its saturating counter, updated together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err     <= 1'b0;
      o_err_cnt <= 8'd0;
    end else begin
      o_err <= err_set;
      if (err_set && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rec_a_unpacker.sv
// tb_rec_a_unpacker: directed tests for rec_a_unpacker. Two instances share
// the byte stream: "s_" is strict on pad bits, "l_" ignores them.
module tb_rec_a_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        valid = 1'b0;
  logic        rdy_in = 1'b0;

  logic        s_ready, s_valid, s_err;
  logic [1:0]  s_kind;
  logic [9:0]  s_a, s_aa;
  logic [31:0] s_aaa;
  logic [7:0]  s_cnt;

  logic        l_ready, l_valid, l_err;
  logic [1:0]  l_kind;
  logic [9:0]  l_a, l_aa;
  logic [31:0] l_aaa;
  logic [7:0]  l_cnt;

  int checks = 0;
  int errors = 0;

  rec_a_unpacker #(.STRICT_HDR(1'b1), .STRICT_PAD(1'b1)) u_strict (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(s_ready),
    .o_valid(s_valid), .i_ready(rdy_in), .o_kind(s_kind), .o_a(s_a), .o_aa(s_aa),
    .o_aaa(s_aaa), .o_err(s_err), .o_err_cnt(s_cnt)
  );

  rec_a_unpacker #(.STRICT_HDR(1'b1), .STRICT_PAD(1'b0)) u_lax (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(l_ready),
    .o_valid(l_valid), .i_ready(rdy_in), .o_kind(l_kind), .o_a(l_a), .o_aa(l_aa),
    .o_aaa(l_aaa), .o_err(l_err), .o_err_cnt(l_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Offers one byte and returns 1 ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    data = b;
    valid = 1'b1;
    #1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("[TB] FAIL send_timeout byte %02h ready %0b want 1", b, s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready got %0b want 0", s_ready); end
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0b want 0", s_valid); end
    checks++; if (s_kind !== 2'd0) begin errors++; $display("[TB] FAIL rst_kind got %0d want 0", s_kind); end
    checks++; if (s_a !== 10'd0 || s_aa !== 10'd0) begin errors++; $display("[TB] FAIL rst_a_aa got %h/%h want 0/0", s_a, s_aa); end
    checks++; if (s_aaa !== 32'd0) begin errors++; $display("[TB] FAIL rst_aaa got %h want 0", s_aaa); end
    checks++; if (s_err !== 1'b0 || s_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_err got %0b/%0d want 0/0", s_err, s_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %0b want 1", s_ready); end
  endtask

  task automatic test_kind_z();
    logic [7:0] zs [9] = '{8'h03, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    rdy_in = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(zs[i]);
    checks++; if (l_valid !== 1'b0) begin errors++; $display("[TB] FAIL z_early_valid got %0b want 0", l_valid); end
    send_byte(zs[8]);
    valid = 1'b0;
    checks++; if (l_valid !== 1'b1) begin errors++; $display("[TB] FAIL z_valid got %0b want 1", l_valid); end
    checks++; if (l_kind !== 2'd3) begin errors++; $display("[TB] FAIL z_kind got %0d want 3", l_kind); end
    checks++; if (l_a !== 10'h234) begin errors++; $display("[TB] FAIL z_a got %h want 234", l_a); end
    checks++; if (l_aa !== 10'h278) begin errors++; $display("[TB] FAIL z_aa got %h want 278", l_aa); end
    checks++; if (l_aaa !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL z_aaa got %h want deadbeef", l_aaa); end
    checks++; if (s_err !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("[TB] FAIL z_strict_pad err/valid got %0b/%0b want 1/0", s_err, s_valid); end
    checks++; if (s_cnt !== 8'd1) begin errors++; $display("[TB] FAIL z_strict_cnt got %0d want 1", s_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy_in = 1'b1;
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h03);
    checks++; if (s_valid !== 1'b1 || s_kind !== 2'd1) begin errors++; $display("[TB] FAIL x_valid_kind got %0b/%0d want 1/1", s_valid, s_kind); end
    checks++; if (s_a !== 10'h3FF || s_aa !== 10'd0 || s_aaa !== 32'd0) begin errors++; $display("[TB] FAIL x_fields got %h/%h/%h want 3ff/0/0", s_a, s_aa, s_aaa); end
    send_byte(8'h02);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL x_consumed got %0b want 0", s_valid); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    valid = 1'b0;
    checks++; if (s_valid !== 1'b1 || s_kind !== 2'd2) begin errors++; $display("[TB] FAIL y_valid_kind got %0b/%0d want 1/2", s_valid, s_kind); end
    checks++; if (s_a !== 10'h001 || s_aa !== 10'h002 || s_aaa !== 32'd0) begin errors++; $display("[TB] FAIL y_fields got %h/%h/%h want 001/002/0", s_a, s_aa, s_aaa); end
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL y_consumed got %0b want 0", s_valid); end
  endtask

  task automatic test_stall();
    logic [7:0] ys [4] = '{8'h02, 8'h05, 8'h00, 8'h06};
    do_reset();
    rdy_in = 1'b0;
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
    checks++; if (s_valid !== 1'b1 || s_a !== 10'h003) begin errors++; $display("[TB] FAIL stall_first got %0b/%h want 1/003", s_valid, s_a); end
    for (int i = 0; i < 4; i++) begin
      data = ys[i];
      valid = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_byte%0d got %0b want 1", i, s_ready); end
      @(posedge clk); #1;
    end
    data = 8'h00;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_final_ready got %0b want 0", s_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0 || s_valid !== 1'b1 || s_a !== 10'h003 || s_aa !== 10'h004) begin
      errors++; $display("[TB] FAIL stall_hold got rdy %0b v %0b a %h aa %h want 0/1/003/004", s_ready, s_valid, s_a, s_aa);
    end
    @(negedge clk);
    rdy_in = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready got %0b want 1", s_ready); end
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (s_valid !== 1'b1 || s_kind !== 2'd2 || s_a !== 10'h005 || s_aa !== 10'h006) begin
      errors++; $display("[TB] FAIL stall_second got v %0b k %0d a %h aa %h want 1/2/005/006", s_valid, s_kind, s_a, s_aa);
    end
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %0b want 0", s_valid); end
  endtask

  task automatic test_hdr_errors();
    do_reset();
    rdy_in = 1'b1;
    send_byte(8'h00);
    checks++; if (s_err !== 1'b1 || s_cnt !== 8'd1) begin errors++; $display("[TB] FAIL hdr0 err/cnt got %0b/%0d want 1/1", s_err, s_cnt); end
    send_byte(8'h07);
    checks++; if (s_err !== 1'b1 || s_cnt !== 8'd2 || s_valid !== 1'b0) begin errors++; $display("[TB] FAIL hdr7 err/cnt/valid got %0b/%0d/%0b want 1/2/0", s_err, s_cnt, s_valid); end
    send_byte(8'h01);
    checks++; if (s_err !== 1'b0) begin errors++; $display("[TB] FAIL hdr_pulse_width got %0b want 0", s_err); end
    send_byte(8'h0A); send_byte(8'h00);
    valid = 1'b0;
    checks++; if (s_valid !== 1'b1 || s_kind !== 2'd1 || s_a !== 10'h00A || s_cnt !== 8'd2) begin
      errors++; $display("[TB] FAIL hdr_resync got v %0b k %0d a %h cnt %0d want 1/1/00a/2", s_valid, s_kind, s_a, s_cnt);
    end
  endtask

  task automatic test_pad();
    do_reset();
    rdy_in = 1'b1;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    valid = 1'b0;
    checks++; if (s_err !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("[TB] FAIL pad_strict err/valid got %0b/%0b want 1/0", s_err, s_valid); end
    checks++; if (l_valid !== 1'b1 || l_kind !== 2'd1 || l_a !== 10'h000 || l_err !== 1'b0) begin
      errors++; $display("[TB] FAIL pad_lax got v %0b k %0d a %h err %0b want 1/1/000/0", l_valid, l_kind, l_a, l_err);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    rdy_in = 1'b1;
    send_byte(8'h03); send_byte(8'h34); send_byte(8'h12); send_byte(8'h78);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready got %0b want 0", s_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    send_byte(8'h01); send_byte(8'h11); send_byte(8'h00);
    valid = 1'b0;
    checks++; if (s_valid !== 1'b1 || s_kind !== 2'd1 || s_a !== 10'h011 || s_aaa !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_record got v %0b k %0d a %h aaa %h want 1/1/011/0", s_valid, s_kind, s_a, s_aaa);
    end
    checks++; if (s_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_cnt got %0d want 0", s_cnt); end
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_single got %0b want 0", s_valid); end
  endtask

  initial begin
    test_reset();
    test_kind_z();
    test_back_to_back();
    test_stall();
    test_hdr_errors();
    test_pad();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rec_a_unpacker.md
Name: rec_a_unpacker

Overview:
- Byte-stream receiver that rebuilds A records (a: 10 bit, aa: 10 bit, aaa: 32 bit), each tagged with a B kind (X=1, Y=2, Z=3).
- Unpack end of the record link. Consumes the little-endian byte frames produced by the record packer on the transmit side.
- Presents one decoded record at a time on a valid/ready output with a one-entry holding register.

Parameters:
- STRICT_HDR, 1, when 1 a header with nonzero bits[7:2] is a framing error.
- STRICT_PAD, 1, when 1 nonzero bits[7:2] in the high byte of a or aa is a payload error.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_data  input  8  stream byte
- i_valid  input  1  byte valid
- o_ready  output  1  byte accepted when i_valid && o_ready
- o_valid  output  1  record valid
- i_ready  input  1  record consumed when o_valid && i_ready
- o_kind  output  2  B kind: 1=X, 2=Y, 3=Z
- o_a  output  10  field a
- o_aa  output  10  field aa; 0 when absent
- o_aaa  output  32  field aaa; 0 when absent
- o_err  output  1  one-cycle error pulse
- o_err_cnt  output  8  saturating error count

Behaviour:
- Reset (async, i_rst=1): state HDR, byte count 0, assembly registers 0, o_valid=0, all record outputs 0, o_err=0, o_err_cnt=0, o_ready=0 while i_rst is high.
- Frame format: 1 header byte, then payload.
  - Header bits[1:0] = kind. Bits[7:2] are reserved.
  - Payload length by kind: X=2 (a), Y=4 (a, aa), Z=8 (a, aa, aaa).
  - Each field is little-endian.
  - For a and aa, bits[1:0] of the high byte map to field bits[9:8].
- State HDR, on byte accept:
  - kind=0, or (STRICT_HDR && bits[7:2]!=0): pulse o_err the next cycle, stay in HDR. The byte is discarded; resync is on the next byte.
  - Otherwise latch kind, clear assembly registers, count=0, go to PAY.
- State PAY:
  - Each accepted byte is written to the assembly byte lane selected by count, then count increments.
  - STRICT_PAD violation on a high byte sets a sticky frame-error flag.
  - On the final byte (count = length-1):
    - If the frame-error flag is set: pulse o_err, drop the record, go to HDR.
    - Otherwise copy assembly to the output register, set o_valid the next cycle, go to HDR.
- Output register:
  - Holds its value while o_valid && !i_ready.
  - o_valid clears on the cycle after consumption, unless a new record loads in the same cycle. In that case o_valid stays 1 and the fields update.
- o_ready:
  - 1 in HDR and in PAY before the final byte, including while o_valid is pending. Header and payload bytes of the next frame overlap a stalled output.
  - On the final byte, o_ready = !o_valid || i_ready. Combinational from i_ready is permitted.
  - Dropped frames (error) never wait on the output slot.
- Latency: final byte accepted at cycle N, record visible with o_valid=1 at cycle N+1. Sustained throughput is one byte per cycle with i_ready held at 1.
- o_err_cnt: increments once per o_err pulse and saturates at 255.
- i_valid=0 mid-frame: state and count are held indefinitely. There is no timeout.
- Reset mid-frame: the partial frame is discarded and the pending output is lost. After release, the first byte is treated as a header.

Test Plan:
- Kind Z stream 03 34 12 78 56 EF BE AD DE, i_ready=1 -> one cycle after the last byte: o_valid=1, kind=3, a=0x234, aa=0x278, aaa=0xDEADBEEF.
- Kind X stream 01 FF 03, then kind Y stream 02 01 00 02 00 back-to-back -> record {1, 0x3FF, 0, 0}, then record {2, 0x001, 0x002, 0}. No idle cycles needed.
- Kind Y record pending with i_ready=0, next frame 02 05 00 06 00 sent -> o_ready=1 for the first 4 bytes and 0 on the final byte. Raise i_ready -> the final byte is accepted in the same cycle, and the new record appears with o_valid staying high.
- Header 00, then header 07 -> o_err pulses twice, o_err_cnt=2, no o_valid. Then 01 0A 00 -> record {1, 0x00A}.
- Frame 01 00 04 -> o_err pulse, no record. Repeat with STRICT_PAD=0 -> record a=0x000 (pad bits ignored).
- Assert i_rst after 4 bytes of a Z frame, release, send 01 11 00 -> only record {1, 0x011}, o_err_cnt=0.
